// File: rtl/alu_arbiter.sv
// Round-robin arbiter that shares one ALU between NUM_REQ requesters, one transaction at a time.
// A watchdog turns a stalled ALU into an error response; late ALU results are drained while idle.
module alu_arbiter #(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 16,
   parameter int SEL_WIDTH  = 3,
   parameter int TIMEOUT    = 15
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic [NUM_REQ-1:0]                req_valid_ip,
   input  logic [NUM_REQ*DATA_WIDTH-1:0]     req_data_1_ip,
   input  logic [NUM_REQ*DATA_WIDTH-1:0]     req_data_2_ip,
   input  logic [NUM_REQ*SEL_WIDTH-1:0]      req_sel_ip,
   input  logic [NUM_REQ-1:0]                req_parity_ip,
   output logic [NUM_REQ-1:0]                req_ready_op,
   output logic [NUM_REQ-1:0]                rsp_valid_op,
   output logic [2*DATA_WIDTH-1:0]           rsp_data_op,
   output logic                              rsp_err_op,
   input  logic [NUM_REQ-1:0]                rsp_ready_ip,
   output logic                              alu_valid_op,
   output logic [DATA_WIDTH-1:0]             alu_data_1_op,
   output logic [DATA_WIDTH-1:0]             alu_data_2_op,
   output logic [SEL_WIDTH-1:0]              alu_sel_op,
   output logic                              alu_parity_op,
   input  logic                              alu_ready_ip,
   input  logic                              alu_valid_ip,
   input  logic [2*DATA_WIDTH-1:0]           alu_data_ip,
   input  logic                              alu_err_ip,
   output logic                              alu_ready_op,
   output logic                              busy_op,
   output logic [$clog2(NUM_REQ)-1:0]        grant_id_op,
   output logic [1:0]                        state_op
);

   localparam int IDW = $clog2(NUM_REQ);
   localparam int WDW = $clog2(TIMEOUT + 1);

   // Handshakes: a transfer occurs at a rising edge where valid and ready are both high;
   // req_ready_op is a one-cycle accept pulse, all other valids hold their payload until accepted.
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RES, RESPOND} state_t;

   state_t                  state;
   logic [IDW-1:0]          last_grant;
   logic [WDW-1:0]          wd_cnt;
   logic                    wd_expire;
   logic                    win_found;
   logic [IDW-1:0]          win_id;
   logic [IDW-1:0]          cand;
   logic [DATA_WIDTH-1:0]   win_d1;
   logic [DATA_WIDTH-1:0]   win_d2;
   logic [SEL_WIDTH-1:0]    win_sel;
   logic                    win_par;

   assign state_op  = state;
   // Counter saturates one short of TIMEOUT so a late ISSUE handshake still times out in WAIT_RES.
   assign wd_expire = (wd_cnt >= WDW'(TIMEOUT - 1));

   always_comb begin
      win_found = 1'b0;
      win_id    = '0;
      cand      = '0;
      win_d1    = '0;
      win_d2    = '0;
      win_sel   = '0;
      win_par   = 1'b0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         cand = IDW'((int'(last_grant) + k) % NUM_REQ);
         if (!win_found && req_valid_ip[cand]) begin
            win_found = 1'b1;
            win_id    = cand;
         end
      end
      for (int i = 0; i < NUM_REQ; i++) begin
         if (win_id == IDW'(i)) begin
            win_d1  = req_data_1_ip[i*DATA_WIDTH +: DATA_WIDTH];
            win_d2  = req_data_2_ip[i*DATA_WIDTH +: DATA_WIDTH];
            win_sel = req_sel_ip[i*SEL_WIDTH +: SEL_WIDTH];
            win_par = req_parity_ip[i];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= IDLE;
         last_grant    <= IDW'(NUM_REQ - 1);
         wd_cnt        <= '0;
         grant_id_op   <= '0;
         req_ready_op  <= '0;
         rsp_valid_op  <= '0;
         rsp_data_op   <= '0;
         rsp_err_op    <= 1'b0;
         alu_valid_op  <= 1'b0;
         alu_data_1_op <= '0;
         alu_data_2_op <= '0;
         alu_sel_op    <= '0;
         alu_parity_op <= 1'b0;
         alu_ready_op  <= 1'b0;
         busy_op       <= 1'b0;
      end else begin
         req_ready_op <= '0;
         alu_ready_op <= 1'b0;
         case (state)
            IDLE: begin
               if (alu_valid_ip && !alu_ready_op)
                  alu_ready_op <= 1'b1;
               if (win_found) begin
                  grant_id_op   <= win_id;
                  req_ready_op  <= NUM_REQ'(1) << win_id;
                  alu_data_1_op <= win_d1;
                  alu_data_2_op <= win_d2;
                  alu_sel_op    <= win_sel;
                  alu_parity_op <= win_par;
                  alu_valid_op  <= 1'b1;
                  wd_cnt        <= '0;
                  busy_op       <= 1'b1;
                  state         <= ISSUE;
               end
            end
            ISSUE: begin
               if (!wd_expire)
                  wd_cnt <= wd_cnt + WDW'(1);
               if (alu_ready_ip) begin
                  alu_valid_op <= 1'b0;
                  state        <= WAIT_RES;
               end else if (wd_expire) begin
                  alu_valid_op <= 1'b0;
                  rsp_data_op  <= '0;
                  rsp_err_op   <= 1'b1;
                  rsp_valid_op <= NUM_REQ'(1) << grant_id_op;
                  state        <= RESPOND;
               end
            end
            WAIT_RES: begin
               if (!wd_expire)
                  wd_cnt <= wd_cnt + WDW'(1);
               if (alu_valid_ip) begin
                  rsp_data_op  <= alu_data_ip;
                  rsp_err_op   <= alu_err_ip;
                  alu_ready_op <= 1'b1;
                  rsp_valid_op <= NUM_REQ'(1) << grant_id_op;
                  state        <= RESPOND;
               end else if (wd_expire) begin
                  rsp_data_op  <= '0;
                  rsp_err_op   <= 1'b1;
                  rsp_valid_op <= NUM_REQ'(1) << grant_id_op;
                  state        <= RESPOND;
               end
            end
            RESPOND: begin
               if (rsp_ready_ip[grant_id_op]) begin
                  rsp_valid_op <= '0;
                  last_grant   <= grant_id_op;
                  busy_op      <= 1'b0;
                  state        <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed scenarios, an emulated ALU, and a transaction-rule model
// whose predicted outputs are compared with the DUT on every cycle.
module tb_alu_arbiter;
   localparam int N  = 4;
   localparam int DW = 16;
   localparam int SW = 3;
   localparam int TO = 15;

   logic          clk = 1'b0;
   logic          rst;
   logic [N-1:0]  req_valid_ip;
   logic [N*DW-1:0] req_data_1_ip, req_data_2_ip;
   logic [N*SW-1:0] req_sel_ip;
   logic [N-1:0]  req_parity_ip;
   logic [N-1:0]  req_ready_op, rsp_valid_op, rsp_ready_ip;
   logic [2*DW-1:0] rsp_data_op, alu_data_ip;
   logic          rsp_err_op, alu_valid_op, alu_parity_op, alu_ready_ip;
   logic          alu_valid_ip, alu_err_ip, alu_ready_op, busy_op;
   logic [DW-1:0] alu_data_1_op, alu_data_2_op;
   logic [SW-1:0] alu_sel_op;
   logic [1:0]    grant_id_op, state_op;

   alu_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .SEL_WIDTH(SW), .TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst),
      .req_valid_ip(req_valid_ip), .req_data_1_ip(req_data_1_ip), .req_data_2_ip(req_data_2_ip),
      .req_sel_ip(req_sel_ip), .req_parity_ip(req_parity_ip), .req_ready_op(req_ready_op),
      .rsp_valid_op(rsp_valid_op), .rsp_data_op(rsp_data_op), .rsp_err_op(rsp_err_op),
      .rsp_ready_ip(rsp_ready_ip),
      .alu_valid_op(alu_valid_op), .alu_data_1_op(alu_data_1_op), .alu_data_2_op(alu_data_2_op),
      .alu_sel_op(alu_sel_op), .alu_parity_op(alu_parity_op), .alu_ready_ip(alu_ready_ip),
      .alu_valid_ip(alu_valid_ip), .alu_data_ip(alu_data_ip), .alu_err_ip(alu_err_ip),
      .alu_ready_op(alu_ready_op), .busy_op(busy_op), .grant_id_op(grant_id_op),
      .state_op(state_op)
   );

   // clock / reset
   always #5 clk = ~clk;

   int n_pass  = 0;
   int n_total = 0;
   bit cmp_en  = 1'b0;

   // ALU emulator controls (written only by the main sequence)
   int res_delay  = 0;
   bit err_mode   = 1'b0;
   int late_req_n = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic neg;
      @(negedge clk);
   endtask

   task automatic set_req(input int i, input logic [DW-1:0] a, input logic [DW-1:0] b,
                          input logic [SW-1:0] s, input logic p);
      req_data_1_ip[i*DW +: DW] = a;
      req_data_2_ip[i*DW +: DW] = b;
      req_sel_ip[i*SW +: SW]    = s;
      req_parity_ip[i]          = p;
   endtask

   task automatic wait_idle;
      bit done = 1'b0;
      for (int c = 0; c < 50 && !done; c++) begin
         tick;
         neg;
         if (!busy_op) done = 1'b1;
      end
      chk("idle_bound", busy_op, 0);
   endtask

   function automatic int onehot_idx(input logic [N-1:0] v);
      for (int i = 0; i < N; i++) if (v[i]) return i;
      return -1;
   endfunction

   function automatic logic [2*DW-1:0] alu_fn(input logic [SW-1:0] s, input logic [DW-1:0] a,
                                               input logic [DW-1:0] b);
      if (s == 0) return {{DW{1'b0}}, a} + {{DW{1'b0}}, b};
      return {{DW{1'b0}}, a} * {{DW{1'b0}}, b};
   endfunction

   // Emulated ALU: accepts with alu_ready_ip, returns a result res_delay cycles later,
   // holds it until alu_ready_op is seen; late_req_n injects an unsolicited result.
   initial begin
      logic s_acc, s_rel;
      logic [DW-1:0] pa, pb;
      logic [SW-1:0] ps;
      int cnt = -1;
      int late_done = 0;
      alu_valid_ip = 1'b0;
      alu_data_ip  = '0;
      alu_err_ip   = 1'b0;
      pa = '0; pb = '0; ps = '0;
      forever begin
         @(posedge clk);
         s_acc = alu_valid_op && alu_ready_ip;
         s_rel = alu_ready_op;
         if (s_acc) begin
            pa = alu_data_1_op; pb = alu_data_2_op; ps = alu_sel_op;
         end
         #1;
         if (alu_valid_ip && s_rel) alu_valid_ip = 1'b0;
         if (s_acc) cnt = res_delay;
         else if (cnt > 0) cnt--;
         if (cnt == 0) begin
            alu_valid_ip = 1'b1;
            alu_data_ip  = alu_fn(ps, pa, pb);
            alu_err_ip   = err_mode;
            cnt          = -1;
         end
         if (late_req_n != late_done) begin
            late_done    = late_req_n;
            alu_valid_ip = 1'b1;
            alu_data_ip  = 32'hdead_beef;
            alu_err_ip   = 1'b0;
         end
      end
   end

   // Reference model: one transaction at a time, described as grant / issue / await / respond.
   function automatic int rr_pick(input logic [N-1:0] v, input int last);
      for (int k = 1; k <= N; k++) begin
         int c = (last + k) % N;
         if (v[c]) return c;
      end
      return -1;
   endfunction

   logic [N-1:0]    e_req_ready, e_rsp_valid;
   logic            e_alu_valid, e_alu_ready, e_rsp_err, e_busy, e_par;
   logic [2*DW-1:0] e_rsp_data;
   logic [1:0]      e_grant;
   logic [DW-1:0]   e_a, e_b;
   logic [SW-1:0]   e_sel;
   bit              m_active;
   int              m_last, m_id, m_stage, m_age;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_active <= 1'b0; m_stage <= 0; m_last <= N - 1; m_id <= 0; m_age <= 0;
         e_req_ready <= '0; e_rsp_valid <= '0; e_alu_valid <= 1'b0; e_alu_ready <= 1'b0;
         e_rsp_err <= 1'b0; e_busy <= 1'b0; e_par <= 1'b0; e_rsp_data <= '0; e_grant <= '0;
         e_a <= '0; e_b <= '0; e_sel <= '0;
      end else begin
         automatic int w = rr_pick(req_valid_ip, m_last);
         e_req_ready <= '0;
         e_alu_ready <= 1'b0;
         if (!m_active) begin
            if (alu_valid_ip && !e_alu_ready) e_alu_ready <= 1'b1;
            if (w >= 0) begin
               m_id <= w; m_active <= 1'b1; m_stage <= 1; m_age <= 0;
               e_grant <= 2'(w);
               e_req_ready <= N'(1 << w);
               e_a <= req_data_1_ip[w*DW +: DW];
               e_b <= req_data_2_ip[w*DW +: DW];
               e_sel <= req_sel_ip[w*SW +: SW];
               e_par <= req_parity_ip[w];
               e_alu_valid <= 1'b1;
               e_busy <= 1'b1;
            end
         end else if (m_stage == 1 || m_stage == 2) begin
            m_age <= m_age + 1;
            if (m_stage == 1 && alu_ready_ip) begin
               e_alu_valid <= 1'b0;
               m_stage <= 2;
            end else if (m_stage == 2 && alu_valid_ip) begin
               e_rsp_data <= alu_data_ip;
               e_rsp_err <= alu_err_ip;
               e_alu_ready <= 1'b1;
               e_rsp_valid <= N'(1 << m_id);
               m_stage <= 3;
            end else if (m_age + 1 >= TO) begin
               e_rsp_data <= '0;
               e_rsp_err <= 1'b1;
               e_alu_valid <= 1'b0;
               e_rsp_valid <= N'(1 << m_id);
               m_stage <= 3;
            end
         end else if (rsp_ready_ip[m_id]) begin
            e_rsp_valid <= '0;
            m_last <= m_id;
            m_active <= 1'b0;
            e_busy <= 1'b0;
            m_stage <= 0;
         end
      end
   end

   // scoreboard: model vs DUT on every cycle
   always @(negedge clk) begin
      if (cmp_en) begin
         chk("req_ready", req_ready_op, e_req_ready);
         chk("rsp_valid", rsp_valid_op, e_rsp_valid);
         chk("rsp_data", rsp_data_op, e_rsp_data);
         chk("rsp_err", rsp_err_op, e_rsp_err);
         chk("alu_valid", alu_valid_op, e_alu_valid);
         chk("alu_ready", alu_ready_op, e_alu_ready);
         chk("busy", busy_op, e_busy);
         chk("grant_id", grant_id_op, e_grant);
         chk("alu_data_1", alu_data_1_op, e_a);
         chk("alu_data_2", alu_data_2_op, e_b);
         chk("alu_sel", alu_sel_op, e_sel);
         chk("alu_parity", alu_parity_op, e_par);
      end
   end

   initial begin
      #100000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "bench timeout");
   end

   // main sequence
   initial begin
      int gid[5];
      int gcyc[5];
      int ng, c, lat, drains;
      bit seen, prev_av;
      int exp_order[5];
      exp_order = '{3, 0, 1, 2, 3};
      rst = 1'b1;
      req_valid_ip = '0; req_data_1_ip = '0; req_data_2_ip = '0; req_sel_ip = '0;
      req_parity_ip = '0; rsp_ready_ip = '0; alu_ready_ip = 1'b1;
      tick; tick;
      neg;
      chk("reset_req_ready", req_ready_op, 0);
      chk("reset_rsp_valid", rsp_valid_op, 0);
      chk("reset_alu_valid", alu_valid_op, 0);
      chk("reset_busy", busy_op, 0);
      chk("reset_grant", grant_id_op, 0);
      chk("reset_state", state_op, 0);
      tick;
      rst = 1'b0;
      cmp_en = 1'b1;

      // single request from requester 2: 3 + 4
      tick;
      set_req(2, 16'h0003, 16'h0004, 3'd0, 1'b1);
      req_valid_ip = 4'b0100;
      rsp_ready_ip = 4'b1111;
      neg;
      tick; req_valid_ip = '0; neg;
      chk("t1_req_ready", req_ready_op, 4'b0100);
      chk("t1_alu_valid_c1", alu_valid_op, 1);
      tick; neg;
      chk("t1_alu_valid_c2", alu_valid_op, 0);
      tick; neg;
      chk("t1_rsp_valid", rsp_valid_op, 4'b0100);
      chk("t1_rsp_data", rsp_data_op, 32'h0000_0007);
      chk("t1_rsp_err", rsp_err_op, 0);
      tick; neg;
      chk("t1_idle", busy_op, 0);

      // contention: all four valid, starting after grant 2
      tick;
      for (int i = 0; i < N; i++) set_req(i, 16'(16'h10 + i), 16'(i + 1), 3'(i), 1'(i));
      req_valid_ip = 4'b1111;
      neg;
      ng = 0;
      for (int k = 0; k < 40 && ng < 5; k++) begin
         tick; neg;
         if (req_ready_op != 0) begin
            gid[ng] = onehot_idx(req_ready_op);
            gcyc[ng] = k;
            ng++;
         end
      end
      tick; req_valid_ip = '0;
      chk("t2_grant_count", ng, 5);
      for (int k = 0; k < ng; k++) begin
         chk("t2_grant_order", gid[k], exp_order[k]);
         if (k > 0) chk("t2_grant_spacing", gcyc[k] - gcyc[k-1], 4);
      end
      wait_idle;

      // backpressure on requester 1 while requester 0 waits
      tick;
      set_req(1, 16'h0100, 16'h0003, 3'd1, 1'b0);
      req_valid_ip = 4'b0010;
      rsp_ready_ip = 4'b0000;
      neg;
      tick; req_valid_ip = 4'b0001; rsp_ready_ip = 4'b1101; neg;
      chk("t3_req_ready", req_ready_op, 4'b0010);
      tick; neg;
      tick; neg;
      chk("t3_rsp_valid", rsp_valid_op, 4'b0010);
      chk("t3_rsp_data", rsp_data_op, 32'h0000_0300);
      for (int k = 0; k < 10; k++) begin
         tick; neg;
         chk("t3_hold_valid", rsp_valid_op, 4'b0010);
         chk("t3_hold_data", rsp_data_op, 32'h0000_0300);
         chk("t3_hold_busy", busy_op, 1);
         chk("t3_no_grant", req_ready_op, 0);
      end
      tick; rsp_ready_ip = 4'b0010; neg;
      tick; rsp_ready_ip = 4'b1111; neg;
      chk("t3_released", busy_op, 0);
      tick; req_valid_ip = '0; neg;
      chk("t3_next_grant", req_ready_op, 4'b0001);
      wait_idle;

      // ALU never accepts: watchdog response
      tick;
      alu_ready_ip = 1'b0;
      set_req(3, 16'h0007, 16'h0008, 3'd0, 1'b1);
      req_valid_ip = 4'b1000;
      neg;
      tick; req_valid_ip = '0; neg;
      chk("t4_req_ready", req_ready_op, 4'b1000);
      lat = -1; seen = 1'b0; prev_av = 1'b0;
      for (int k = 2; k < 30 && !seen; k++) begin
         prev_av = alu_valid_op;
         tick; neg;
         if (rsp_valid_op != 0) begin
            seen = 1'b1;
            lat = k;
         end
      end
      chk("t4_timeout_cycle", lat, 1 + TO);
      chk("t4_alu_valid_before", prev_av, 1);
      chk("t4_rsp_valid", rsp_valid_op, 4'b1000);
      chk("t4_rsp_err", rsp_err_op, 1);
      chk("t4_rsp_data", rsp_data_op, 0);
      chk("t4_alu_valid_after", alu_valid_op, 0);
      tick; neg;
      chk("t4_idle", busy_op, 0);
      tick; late_req_n++;
      drains = 0;
      for (int k = 0; k < 8; k++) begin
         tick; neg;
         if (alu_ready_op) drains++;
         chk("t4_no_response", rsp_valid_op, 0);
      end
      chk("t4_drain_pulses", drains, 1);
      alu_ready_ip = 1'b1;

      // ALU error flag passes through with its data
      tick;
      err_mode = 1'b1;
      set_req(0, 16'h0005, 16'h0006, 3'd0, 1'b0);
      req_valid_ip = 4'b0001;
      neg;
      tick; req_valid_ip = '0; neg;
      tick; neg;
      tick; neg;
      chk("t5_rsp_valid", rsp_valid_op, 4'b0001);
      chk("t5_rsp_data", rsp_data_op, 32'h0000_000b);
      chk("t5_rsp_err", rsp_err_op, 1);
      wait_idle;
      err_mode = 1'b0;

      // asynchronous reset while waiting for a slow ALU
      res_delay = 5;
      tick;
      set_req(2, 16'h0009, 16'h0002, 3'd0, 1'b0);
      req_valid_ip = 4'b0100;
      tick; req_valid_ip = '0;
      tick;
      #2 rst = 1'b1;
      #1;
      chk("t6_rst_busy", busy_op, 0);
      chk("t6_rst_alu_valid", alu_valid_op, 0);
      chk("t6_rst_rsp_valid", rsp_valid_op, 0);
      chk("t6_rst_req_ready", req_ready_op, 0);
      chk("t6_rst_grant", grant_id_op, 0);
      chk("t6_rst_alu_data", alu_data_1_op, 0);
      #2 rst = 1'b0;
      drains = 0;
      for (int k = 0; k < 10; k++) begin
         tick; neg;
         if (alu_ready_op) drains++;
         chk("t6_no_response", rsp_valid_op, 0);
      end
      chk("t6_drain_pulses", drains, 1);
      res_delay = 0;
      tick; req_valid_ip = 4'b1111; neg;
      tick; req_valid_ip = '0; neg;
      chk("t6_first_after_reset", req_ready_op, 4'b0001);
      chk("t6_grant_id", grant_id_op, 0);
      wait_idle;

      c = 0;
      tick;
      cmp_en = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
